// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue: 2-wide in-order fetch-to-decode FIFO with compaction, flush and back-pressure.
// Optional same-cycle bypass when empty: define FETCH_Q_BYPASS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
module fetch_instr_queue #(
  parameter int DEPTH = 8,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ext_flush,
  input  logic [1:0]                in_valid,
  input  logic [2*ADDR_WIDTH-1:0]   in_pc,
  input  logic [63:0]               in_instr,
  input  logic [1:0]                in_guesses_br,
  input  logic [2*ADDR_WIDTH-1:0]   in_prediction,
  output logic                      q_stall,
  output logic [1:0]                out_valid,
  output logic [2*ADDR_WIDTH-1:0]   out_pc,
  output logic [63:0]               out_instr,
  output logic [1:0]                out_guesses_br,
  output logic [2*ADDR_WIDTH-1:0]   out_prediction,
  input  logic [1:0]                deq_ready,
  output logic [$clog2(DEPTH):0]    occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = ADDR_WIDTH;
  localparam int EW = 2*AW + 33;
  localparam logic [PW:0] LIM = (PW+1)'(DEPTH-2);
  typedef logic [EW-1:0] ent_t;
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  ent_t mem [DEPTH];
  ent_t ie [2];
  ent_t ce [2];
  ent_t qe [2];
  ent_t oe [2];
  logic [1:0] cv, qv, v, d, n_enq, n_deq, n_wr, skip, hd;
  logic bp, enq_ok;
  // Entry layout: {pc, instr, guesses_br, prediction}
  always_comb begin
    for (int k = 0; k < 2; k++)
      ie[k] = {in_pc[k*AW +: AW], in_instr[k*32 +: 32], in_guesses_br[k], in_prediction[k*AW +: AW]};
    ce[0] = in_valid[0] ? ie[0] : ie[1];
    ce[1] = ie[1];
    cv = {&in_valid, |in_valid};
    n_enq = {1'b0, cv[0]} + {1'b0, cv[1]};
    q_stall = count > LIM;
    qe[0] = mem[head];
    qe[1] = mem[head + PW'(1)];
    qv = {|count[PW:1], |count};
`ifdef FETCH_Q_BYPASS_EN
    bp = reset && count == '0 && !ext_flush;
`else
    bp = 1'b0;
`endif
    v = bp ? cv : qv;
    for (int k = 0; k < 2; k++) begin
      oe[k] = v[k] ? (bp ? ce[k] : qe[k]) : '0;
      out_pc[k*AW +: AW] = oe[k][EW-1 -: AW];
      out_instr[k*32 +: 32] = oe[k][AW+32:AW+1];
      out_guesses_br[k] = oe[k][AW];
      out_prediction[k*AW +: AW] = oe[k][AW-1:0];
    end
    out_valid = v;
    d[0] = v[0] & deq_ready[0];
    d[1] = d[0] & v[1] & deq_ready[1];
    n_deq = {1'b0, d[0]} + {1'b0, d[1]};
    enq_ok = !q_stall && !ext_flush;
    // Bypassed entries taken by decode this cycle skip the RAM entirely
    skip = bp ? n_deq : 2'd0;
    n_wr = enq_ok ? n_enq - skip : 2'd0;
    hd = bp ? 2'd0 : n_deq;
    occupancy = count;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (ext_flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(hd);
      tail <= tail + PW'(n_wr);
      count <= count + (PW+1)'(n_wr) - (PW+1)'(hd);
    end
  always_ff @(posedge clk) begin
    if (reset && n_wr != 2'd0) mem[tail] <= ce[skip[0]];
    if (reset && n_wr == 2'd2) mem[tail + PW'(1)] <= ce[1];
  end
endmodule

// File: tb/tb_fetch_instr_queue.sv
// tb_fetch_instr_queue: vector table plus queue scoreboard for fetch_instr_queue (DEPTH=8, AW=32).
module tb_fetch_instr_queue;
  localparam int DEPTH = 8;
`ifdef FETCH_Q_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, reset = 0, ext_flush = 0;
  logic [1:0] in_valid = 0, in_guesses_br = 0, deq_ready = 0;
  logic [63:0] in_pc = 0, in_instr = 0, in_prediction = 0;
  logic q_stall;
  logic [1:0] out_valid, out_guesses_br;
  logic [63:0] out_pc, out_instr, out_prediction;
  logic [3:0] occupancy;
  typedef struct { logic [31:0] pc, instr; logic gb; logic [31:0] pred; } ent_t;
  typedef struct { logic [1:0] iv; logic [31:0] p0, p1; logic [1:0] dr; logic fl; int occ; logic st; } vec_t;
  ent_t sb[$];
  vec_t tbl [18];
  int total = 0, bad = 0;
  logic [31:0] seq = 32'h1000;
  fetch_instr_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ext_flush(ext_flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_guesses_br(in_guesses_br), .in_prediction(in_prediction),
    .q_stall(q_stall), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_guesses_br(out_guesses_br), .out_prediction(out_prediction), .deq_ready(deq_ready),
    .occupancy(occupancy));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic check_state();
    int n = sb.size();
    chk("occupancy", occupancy, n);
    chk("q_stall", q_stall, n > DEPTH-2);
    chk("out_valid", out_valid, {n >= 2, n >= 1});
    chk("head_pc", out_pc[31:0], n >= 1 ? sb[0].pc : 32'h0);
    chk("head_instr", out_instr[31:0], n >= 1 ? sb[0].instr : 32'h0);
    chk("next_pc", out_pc[63:32], n >= 2 ? sb[1].pc : 32'h0);
  endtask
  task automatic cyc(input logic [1:0] iv, input logic [31:0] p0, input logic [31:0] p1,
                     input logic [1:0] dr, input logic fl);
    ent_t e [2];
    int sz, avail, np;
    ent_t t;
    e[0].pc = p0; e[1].pc = p1;
    for (int k = 0; k < 2; k++) begin
      e[k].instr = $urandom;
      e[k].gb = 1'($urandom_range(1));
      e[k].pred = $urandom;
    end
    in_valid = iv;
    in_pc = {e[1].pc, e[0].pc};
    in_instr = {e[1].instr, e[0].instr};
    in_guesses_br = {e[1].gb, e[0].gb};
    in_prediction = {e[1].pred, e[0].pred};
    deq_ready = dr;
    ext_flush = fl;
    #1;
    if (fl) sb.delete();
    else begin
      sz = sb.size();
      if (sz <= DEPTH-2) begin
        if (iv[0]) sb.push_back(e[0]);
        if (iv[1]) sb.push_back(e[1]);
      end
      avail = (BYP && sz == 0) ? sb.size() : sz;
      np = (dr[0] && avail >= 1) ? ((dr[1] && avail >= 2) ? 2 : 1) : 0;
      for (int k = 0; k < np; k++) begin
        t = sb.pop_front();
        chk("deq_pc", out_pc[k*32 +: 32], t.pc);
        chk("deq_instr", out_instr[k*32 +: 32], t.instr);
        chk("deq_gb", out_guesses_br[k], t.gb);
        chk("deq_pred", out_prediction[k*32 +: 32], t.pred);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    deq_ready = 0;
    ext_flush = 0;
    @(negedge clk);
    check_state();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{2'b11, 32'h10, 32'h14, 2'b00, 1'b0, 2, 1'b0};
    tbl[1]  = '{2'b00, 32'h0,  32'h0,  2'b11, 1'b0, 0, 1'b0};
    tbl[2]  = '{2'b10, 32'h0,  32'h24, 2'b00, 1'b0, 1, 1'b0};
    tbl[3]  = '{2'b11, 32'h30, 32'h34, 2'b00, 1'b0, 3, 1'b0};
    tbl[4]  = '{2'b11, 32'h38, 32'h3c, 2'b00, 1'b0, 5, 1'b0};
    tbl[5]  = '{2'b11, 32'h40, 32'h44, 2'b00, 1'b0, 7, 1'b1};
    tbl[6]  = '{2'b11, 32'hee0, 32'hee4, 2'b11, 1'b0, 5, 1'b0};
    tbl[7]  = '{2'b11, 32'h48, 32'h4c, 2'b01, 1'b0, 6, 1'b0};
    tbl[8]  = '{2'b11, 32'hff0, 32'hff4, 2'b00, 1'b1, 0, 1'b0};
    tbl[9]  = '{2'b01, 32'h50, 32'h0,  2'b00, 1'b0, 1, 1'b0};
    tbl[10] = '{2'b11, 32'h54, 32'h58, 2'b10, 1'b0, 3, 1'b0};
    tbl[11] = '{2'b11, 32'h5c, 32'h60, 2'b00, 1'b0, 5, 1'b0};
    tbl[12] = '{2'b11, 32'h64, 32'h68, 2'b00, 1'b0, 7, 1'b1};
    tbl[13] = '{2'b11, 32'hee8, 32'heec, 2'b00, 1'b0, 7, 1'b1};
    tbl[14] = '{2'b01, 32'hef0, 32'h0,  2'b01, 1'b0, 6, 1'b0};
    tbl[15] = '{2'b11, 32'h6c, 32'h70, 2'b00, 1'b0, 8, 1'b1};
    tbl[16] = '{2'b11, 32'hef8, 32'hefc, 2'b11, 1'b0, 6, 1'b0};
    tbl[17] = '{2'b00, 32'h0,  32'h0,  2'b00, 1'b1, 0, 1'b0};
    in_valid = 2'b11; in_pc = {$urandom, $urandom}; in_instr = {$urandom, $urandom};
    deq_ready = 2'b11;
    repeat (3) @(negedge clk);
    check_state();
    reset = 1;
    in_valid = 0; deq_ready = 0;
    @(negedge clk);
    check_state();
    foreach (tbl[i]) begin
      cyc(tbl[i].iv, tbl[i].p0, tbl[i].p1, tbl[i].dr, tbl[i].fl);
      chk("tbl_occ", occupancy, tbl[i].occ);
      chk("tbl_stall", q_stall, tbl[i].st);
    end
    for (int i = 0; i < 150; i++) begin
      cyc(2'($urandom), seq, seq + 4, 2'($urandom), $urandom_range(40) == 0);
      seq += 8;
    end
    repeat (5) cyc(2'b00, 0, 0, 2'b11, 1'b0);
    chk("drained", occupancy, 0);
`ifdef FETCH_Q_BYPASS_EN
    cyc(2'b11, 32'h200, 32'h204, 2'b11, 1'b0);
    chk("bypass_occ", occupancy, 0);
`endif
    repeat (3) begin
      cyc(2'b11, seq, seq + 4, 2'b00, 1'b0);
      seq += 8;
    end
    #2 reset = 0;
    in_valid = 2'b11;
    #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_stall", q_stall, 0);
    sb.delete();
    @(negedge clk);
    check_state();
    reset = 1;
    in_valid = 0;
    @(negedge clk);
    check_state();
    cyc(2'b11, 32'h300, 32'h304, 2'b00, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
